// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline constants for the hazard/flow-control block: writeback and
// forwarding selects, FSM state encoding and the canonical nop instruction.
package hazard_ctrl_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM = 2'b01;

  localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// EX-operand forwarding comparator: picks MEM, then WB, then the register file.
// x0 is never forwarded; write enables are active-low.
module hazard_ctrl_unit_fwd_sel
  import hazard_ctrl_unit_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdst_m,
  input  logic             wr_en_m,
  input  logic [REG_W-1:0] rdst_w,
  input  logic             wr_en_w,
  output logic [SEL_W-1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (!wr_en_m && (rdst_m != '0) && (rdst_m == rs)) begin
      sel = FWD_MEM;
    end else if (!wr_en_w && (rdst_w != '0) && (rdst_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/flow control: load-use stall, redirect flush, EX forwarding
// and halt drain sequencing. Optional perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned HALT_DRAIN = 3
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic             UsesRs1_D,
  input  logic             UsesRs2_D,
  input  logic [REG_W-1:0] Rs1_E,
  input  logic [REG_W-1:0] Rs2_E,
  input  logic [REG_W-1:0] Rdst_E,
  input  logic [REG_W-1:0] Rdst_M,
  input  logic [REG_W-1:0] Rdst_W,
  input  logic             RegWrEn_E,
  input  logic             RegWrEn_M,
  input  logic             RegWrEn_W,
  input  logic [SEL_W-1:0] WBSel_E,
  input  logic             redirect_E,
  input  logic             halt_D,
  output logic             stall_IF_ID,
  output logic             nop_IF_ID,
  output logic             stall_ID_EX,
  output logic             nop_ID_EX,
  output logic             PC_WEN,
  output logic [SEL_W-1:0] FwdA_E,
  output logic [SEL_W-1:0] FwdB_E,
  output logic             halted
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(HALT_DRAIN + 1);

  hz_state_e        state;
  logic [CNT_W-1:0] count;
  logic             load_use;
  logic             take_stall;
  logic             take_flush;
  logic             take_halt;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;

  hazard_ctrl_unit_fwd_sel u_fwd_a (
    .rs      (Rs1_E),
    .rdst_m  (Rdst_M),
    .wr_en_m (RegWrEn_M),
    .rdst_w  (Rdst_W),
    .wr_en_w (RegWrEn_W),
    .sel     (fwd_a)
  );

  hazard_ctrl_unit_fwd_sel u_fwd_b (
    .rs      (Rs2_E),
    .rdst_m  (Rdst_M),
    .wr_en_m (RegWrEn_M),
    .rdst_w  (Rdst_W),
    .wr_en_w (RegWrEn_W),
    .sel     (fwd_b)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = (WBSel_E == WB_MEM) && !RegWrEn_E && (Rdst_E != '0) &&
               ((UsesRs1_D && (Rs1_D == Rdst_E)) || (UsesRs2_D && (Rs2_D == Rdst_E)));
    take_flush = (state == RUN) && redirect_E;
    take_stall = (state == RUN) && !redirect_E && load_use;
    take_halt  = (state == RUN) && !redirect_E && !load_use && halt_D;
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take_halt) begin
            state <= DRAIN;
            count <= CNT_W'(HALT_DRAIN);
          end
        end
        DRAIN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    stall_IF_ID = 1'b0;
    nop_IF_ID   = 1'b0;
    stall_ID_EX = 1'b0;
    nop_ID_EX   = 1'b0;
    PC_WEN      = 1'b0;
    FwdA_E      = FWD_REG;
    FwdB_E      = FWD_REG;
    if (!RST) begin
      FwdA_E = fwd_a;
      FwdB_E = fwd_b;
      if (state != RUN) begin
        PC_WEN    = 1'b1;
        nop_IF_ID = 1'b1;
      end else if (take_flush) begin
        nop_IF_ID = 1'b1;
        nop_ID_EX = 1'b1;
      end else if (take_stall) begin
        stall_IF_ID = 1'b1;
        nop_ID_EX   = 1'b1;
        PC_WEN      = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counters; they only advance in RUN so they freeze once halted.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (take_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (take_flush && (flush_cycles != '1)) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central hazard and flow-control block for the 5-stage RISC-V pipeline.
- Consumes stage-tagged register and control info from the ID, EX, MEM and WB pipeline registers.
- Drives the stall/nop inputs of the IF/ID and ID/EX registers, the PC write enable, and the EX-stage forwarding selects.
- Sequences the halt drain: stops fetch when halt is decoded, then asserts halted once the halt instruction retires.

Parameters:
- HALT_DRAIN, 3, cycles from halt_D acceptance until the halt reaches WB.
- XLEN, 32, PC width.

Ports:
- CLK  in  1  clock; all state updates on the negedge, aligned with the pipeline registers.
- RST  in  1  reset, asynchronous, active-high.
- Rs1_D  in  5  ID-stage source register 1.
- Rs2_D  in  5  ID-stage source register 2.
- UsesRs1_D  in  1  ID instruction reads rs1.
- UsesRs2_D  in  1  ID instruction reads rs2.
- Rs1_E  in  5  EX-stage source register 1.
- Rs2_E  in  5  EX-stage source register 2.
- Rdst_E  in  5  EX-stage destination register.
- Rdst_M  in  5  MEM-stage destination register.
- Rdst_W  in  5  WB-stage destination register.
- RegWrEn_E  in  1  active-low register write enable, EX stage.
- RegWrEn_M  in  1  active-low register write enable, MEM stage.
- RegWrEn_W  in  1  active-low register write enable, WB stage.
- WBSel_E  in  2  EX-stage writeback select; WB_MEM (2'b01) marks a load.
- redirect_E  in  1  taken branch or jump resolved in EX.
- halt_D  in  1  halt decoded in ID.
- stall_IF_ID  out  1  hold IF/ID contents.
- nop_IF_ID  out  1  load a nop into IF/ID.
- stall_ID_EX  out  1  hold ID/EX contents.
- nop_ID_EX  out  1  load a nop into ID/EX.
- PC_WEN  out  1  active-low PC write enable.
- FwdA_E  out  2  EX operand A source select.
- FwdB_E  out  2  EX operand B source select.
- halted  out  1  sticky; set once the halt retires.

Behaviour:
- Reset (RST=1, asynchronous): state=RUN, drain count=0, halted=0.
- Reset combinational outputs: stall/nop all 0, PC_WEN=0, Fwd=FWD_REG.
- Reset mid-operation aborts any stall or drain immediately.
- States: RUN, DRAIN, HALTED.
- Load-use hazard (RUN only): WBSel_E==WB_MEM and RegWrEn_E==0 and Rdst_E!=0 and ((UsesRs1_D and Rs1_D==Rdst_E) or (UsesRs2_D and Rs2_D==Rdst_E)).
  - Response, for exactly one cycle: stall_IF_ID=1, nop_ID_EX=1, PC_WEN=1 (hold).
  - The load then advances to MEM, so the condition self-clears; there is no repeat stall.
- Redirect (RUN): redirect_E=1 gives nop_IF_ID=1 and nop_ID_EX=1 for one cycle. PC_WEN=0 so the target is loaded.
  - Redirect has priority over load-use.
  - Redirect has priority over halt_D: a halt in the wrong-path shadow is squashed and the state stays RUN.
- Halt: in RUN, halt_D=1 with no redirect and no load-use moves the FSM to DRAIN at the next negedge and loads count=HALT_DRAIN.
  - If load-use and halt_D coincide, the stall is taken and halt is accepted the following cycle.
- DRAIN:
  - Outputs: PC_WEN=1, nop_IF_ID=1, stall_ID_EX=0, nop_ID_EX=0; no new fetches.
  - Count decrements each negedge. At count==1 the next state is HALTED.
  - redirect_E is ignored in DRAIN; the halt is already committed past EX.
- HALTED: halted=1, PC_WEN=1, nop_IF_ID=1. The FSM leaves HALTED only on reset.
- Forwarding (combinational, every state), operand A shown; B is identical with Rs2_E:
  - Select FWD_MEM(2'b01) if RegWrEn_M==0 and Rdst_M!=0 and Rdst_M==Rs1_E.
  - Otherwise FWD_WB(2'b10) if RegWrEn_W==0 and Rdst_W!=0 and Rdst_W==Rs1_E.
  - Otherwise FWD_REG(2'b00).
  - MEM has priority over WB. x0 is never forwarded.
- stall and nop for the same register are never both 1.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Enabled:
  - Adds 32-bit outputs stall_cycles and flush_cycles, both reset to 0.
  - stall_cycles increments each negedge a load-use stall is asserted.
  - flush_cycles increments each negedge redirect_E is honoured.
  - Both saturate at 32'hFFFFFFFF and freeze in HALTED.
- Disabled: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - WB_ALU, WB_MEM;
  - FWD_REG, FWD_MEM, FWD_WB;
  - the state encoding typedef (RUN/DRAIN/HALTED);
  - the nop instruction constant 32'h13.
- Sub-module fwd_sel: pure combinational forwarding comparator, instantiated once per operand (A and B).

Test Plan:
- Load-use: lw x5 in EX (WBSel_E=01, Rdst_E=5, RegWrEn_E=0), ID add with Rs1_D=5 -> one cycle of stall_IF_ID=1, nop_ID_EX=1, PC_WEN=1; next cycle all 0.
- Redirect during load-use: same as above plus redirect_E=1 -> nop_IF_ID=1, nop_ID_EX=1, stall_IF_ID=0, PC_WEN=0.
- Forwarding: Rs1_E=7, Rdst_M=7, Rdst_W=7, both RegWrEn=0 -> FwdA_E=01. Repeat with Rs1_E=0 -> FwdA_E=00.
- Halt drain: halt_D=1 in RUN -> PC_WEN=1 and nop_IF_ID=1 from the next cycle; halted=1 exactly 3 negedges after acceptance; it stays 1.
- Async reset: assert RST mid-DRAIN, between clock edges -> halted=0, PC_WEN=0, and all stall/nop=0 immediately.
- With HAZ_PERF_CNT_EN: 2 load-use stalls and 1 redirect -> stall_cycles=2, flush_cycles=1.
